// File: rtl/monit_pkg.sv
// Shared types and constants for the monitor sampler and its CRC helper.
package monit_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StCnt,
    StId,
    StData,
    StCrc,
    StEof
  } state_e;

  localparam logic [7:0] CrcPoly   = 8'h07;
  localparam logic [7:0] DefSync   = 8'hA5;
  localparam logic [7:0] DefEof    = 8'h0A;
  localparam logic [7:0] DefIdBase = 8'h30;
  localparam int unsigned DropW    = 16;

  // One byte of CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_next(logic [7:0] crc, logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CrcPoly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/monit_sampler_crc8.sv
// Byte-wide CRC-8 register; only instantiated when MONIT_SAMPLER_CRC_EN is defined.
module monit_crc8
  import monit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] crc
);

  logic [7:0] crc_q;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= crc8_next(crc_q, din);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/monit_sampler.sv
// Multi-channel sampler that frames masked channel snapshots into a byte stream.
// Define MONIT_SAMPLER_CRC_EN to insert a CRC-8 byte before EOF.
module monit_sampler
  import monit_pkg::*;
#(
  parameter int unsigned N_CH      = 8,
  parameter int unsigned WIDTH     = 32,
  parameter logic [7:0]  ID_BASE   = DefIdBase,
  parameter logic [7:0]  SYNC_BYTE = DefSync,
  parameter logic [7:0]  EOF_BYTE  = DefEof
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [31:0]             sample_period,
  input  logic [N_CH-1:0]         ch_mask,
  input  logic [N_CH*WIDTH-1:0]   ch_data,
  input  logic                    clr_overrun,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  output logic [DropW-1:0]        drop_cnt
);

  localparam int unsigned NumBytes = WIDTH / 8;
  localparam int unsigned ChW      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
`ifdef MONIT_SAMPLER_CRC_EN
  localparam state_e AfterData = StCrc;
`else
  localparam state_e AfterData = StEof;
`endif

  state_e                             state_q, state_d;
  logic [31:0]                        per_cnt_q;
  logic                               tick, hs, drop_tick;
  logic [N_CH-1:0][WIDTH-1:0]         snap_q;
  logic [NumBytes-1:0][7:0]           cur_bytes;
  logic [N_CH-1:0]                    mask_q;
  logic [7:0]                         cnt_q, mask_pop;
  logic [ChW-1:0]                     ch_q, ch_d, first_ch, next_ch;
  logic                               has_first, has_next;
  logic [IdxW-1:0]                    idx_q, idx_d;
  logic                               overrun_q, frame_done_q;
  logic [DropW-1:0]                   drop_q;

  assign tx_valid   = (state_q != StIdle);
  assign busy       = tx_valid;
  assign hs         = tx_valid && tx_ready;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign drop_cnt   = drop_q;

  // Compare against period-1 so a lowered period takes effect at once.
  assign tick      = enable && (sample_period != '0) && (per_cnt_q >= sample_period - 32'd1);
  assign drop_tick = tick && (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (!rst || !enable || sample_period == '0 || tick) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_q + 32'd1;
    end
  end

  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      mask_pop = mask_pop + 8'(ch_mask[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_q <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
    end else if (tick && state_q == StIdle) begin
      snap_q <= ch_data;
      mask_q <= ch_mask;
      cnt_q  <= mask_pop;
    end
  end

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    has_first = 1'b0;
    first_ch  = '0;
    has_next  = 1'b0;
    next_ch   = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        has_first = 1'b1;
        first_ch  = ChW'(i);
        if (i > int'(ch_q)) begin
          has_next = 1'b1;
          next_ch  = ChW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: if (tick) state_d = StSync;
      StSync: if (hs) state_d = StCnt;
      StCnt: begin
        if (hs) begin
          if (has_first) begin
            state_d = StId;
            ch_d    = first_ch;
          end else begin
            state_d = AfterData;
          end
        end
      end
      StId: begin
        if (hs) begin
          state_d = StData;
          idx_d   = IdxW'(NumBytes - 1);
        end
      end
      StData: begin
        if (hs) begin
          if (idx_q != '0) begin
            idx_d = idx_q - IdxW'(1);
          end else if (has_next) begin
            state_d = StId;
            ch_d    = next_ch;
          end else begin
            state_d = AfterData;
          end
        end
      end
      StCrc:   if (hs) state_d = StEof;
      StEof:   if (hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      ch_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
    end
  end

  // A drop in the same cycle as a clear wins and restarts the count at 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_q    <= 1'b0;
      drop_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state_q == StEof) && hs;
      if (drop_tick) begin
        overrun_q <= 1'b1;
        if (clr_overrun) begin
          drop_q <= DropW'(1);
        end else if (drop_q != '1) begin
          drop_q <= drop_q + DropW'(1);
        end
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
        drop_q    <= '0;
      end
    end
  end

  assign cur_bytes = snap_q[ch_q];

`ifdef MONIT_SAMPLER_CRC_EN
  logic [7:0] crc_byte;
  logic       crc_en;

  assign crc_en = hs && (state_q == StCnt || state_q == StId || state_q == StData);

  monit_crc8 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (state_q == StIdle),
    .en  (crc_en),
    .din (tx_data),
    .crc (crc_byte)
  );
`endif

  always_comb begin
    tx_data = '0;
    unique case (state_q)
      StSync: tx_data = SYNC_BYTE;
      StCnt:  tx_data = cnt_q;
      StId:   tx_data = ID_BASE + 8'(ch_q);
      StData: tx_data = cur_bytes[idx_q];
`ifdef MONIT_SAMPLER_CRC_EN
      StCrc:  tx_data = crc_byte;
`endif
      StEof:  tx_data = EOF_BYTE;
      default: tx_data = '0;
    endcase
  end

endmodule

// File: doc/monit_sampler.md
# monit_sampler

Parametrised multi-channel monitor front end for the UART debug link. Samples `N_CH` channels of `WIDTH` bits each. Sampling happens on a programmable period, with a per-channel include mask. Each accepted sample is serialised into a framed byte stream over a valid/ready handshake, which drives the UART Tx byte sender in the comm path. It supersedes fixed-count, fixed-32-bit variable framing with hard-wired IDs.

## Interface
- `N_CH`, 8: number of monitored channels (1..32).
- `WIDTH`, 32: channel width in bits; multiple of 8, 8..64.
- `ID_BASE`, 8'h30: ID byte of channel 0; channel i is tagged `ID_BASE+i`.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.
- `EOF_BYTE`, 8'h0A: last byte of every frame.
- `clk`, in, 1: system clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `enable`, in, 1: sampling enable.
- `sample_period`, in, 32: sampling period in `clk` cycles; 0 disables sampling.
- `ch_mask`, in, N_CH: channel i is included in the frame when bit i is 1.
- `ch_data`, in, N_CH*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `clr_overrun`, in, 1: clears `overrun` and `drop_cnt`.
- `tx_data`, out, 8: current frame byte.
- `tx_valid`, out, 1: `tx_data` is valid.
- `tx_ready`, in, 1: sender accepts the byte.
- `busy`, out, 1: a frame is in progress.
- `frame_done`, out, 1: one-cycle pulse after the EOF byte is accepted.
- `overrun`, out, 1: sticky flag; a sample tick occurred while `busy`.
- `drop_cnt`, out, 16: saturating count of dropped ticks.

## Operation
- **Period counter** (`per_cnt`):
  - Increments while `enable` and `sample_period != 0`; otherwise it is held at 0.
  - A tick fires when `per_cnt >= sample_period-1`; the counter then returns to 0.
  - Lowering `sample_period` therefore takes effect immediately.
- **Tick while idle:**
  - Latch all of `ch_data` into the snapshot registers.
  - Latch `ch_mask` into `mask_q`.
  - Latch `popcount(mask_q)` into `cnt_q`.
  - Enter SYNC.
- **Tick while busy:** the sample is dropped. `overrun` is set and `drop_cnt` increments, saturating at 16'hFFFF.
- **Frame byte order:**
  - SYNC_BYTE.
  - `cnt_q`.
  - For each channel i with `mask_q[i]`, in ascending i: ID byte, then WIDTH/8 data bytes, most significant byte first.
  - [CRC byte, see Configuration].
  - EOF_BYTE.
- **Empty mask:** a mask of all zeros gives the frame SYNC, 0x00, [CRC], EOF.
- **FSM states and transitions:**
  - IDLE → SYNC on tick.
  - SYNC → CNT.
  - CNT → ID if any channel is selected, else CRC/EOF.
  - ID → DATA.
  - DATA → ID for the next selected channel after the last byte, else CRC/EOF.
  - CRC → EOF.
  - EOF → IDLE.
  - Every transition happens only on a handshake (`tx_valid && tx_ready`).
- **Next-channel search:** combinational priority search over `mask_q` above the current index; no idle cycles between bytes.
- **Byte index:** counts from WIDTH/8-1 down to 0. The byte is selected as `snap[ch][idx*8 +: 8]`.
- **`clr_overrun` vs. tick:** if `clr_overrun` and a dropped tick occur in the same cycle, the drop wins: the flag stays set and the count becomes 1.

## Timing
- **Reset values:** with `rst` low at a clock edge, every output is 0: `tx_data`, `tx_valid`, `busy`, `frame_done`, `overrun`, `drop_cnt`. The FSM goes to IDLE and `per_cnt` to 0.
- **Reset mid-frame:** aborts the frame. `tx_valid` is 0 on the next cycle and no EOF is sent.
- **Latency:**
  - Tick at cycle T: the snapshot is taken at edge T.
  - `tx_valid`=1 with SYNC_BYTE from cycle T+1.
  - `busy`=1 from T+1 until the cycle after EOF is accepted.
- **Handshake:**
  - `tx_data` is stable while `tx_valid && !tx_ready`.
  - `tx_valid` never drops without a handshake, except on reset.
  - With `tx_ready` held high, one byte is transferred per cycle.
- **`frame_done`:** high for exactly the cycle after EOF is accepted. A tick in that same cycle starts a new frame (the FSM is in IDLE).
- **`enable` deassertion mid-frame:** the current frame completes.
- **Frame length in bytes:** 3 + popcount·(1+WIDTH/8), plus 1 with CRC.

## Configuration
- **`MONIT_SAMPLER_CRC_EN` defined:** a CRC-8 byte is inserted before EOF.
  - Polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Covers every byte from `cnt_q` through the last data byte.
  - SYNC and EOF are excluded.
  - The CRC updates on each handshake.
- **Undefined:** the CRC state is skipped (CNT/DATA → EOF directly) and no CRC logic is synthesised.

## Structure
- **Shared package `monit_pkg`:**
  - FSM state enum.
  - CRC polynomial constant.
  - Default SYNC/EOF/ID_BASE constants.
  - `drop_cnt` width.
- **Sub-module `monit_crc8`:** byte-wide combinational CRC-8 next-state function plus register. It takes `clr` and `en` inputs and is instantiated only under the macro.

## Test plan
- **Basic frame:** N_CH=2, WIDTH=32, mask=2'b11, ch0=32'h11223344, ch1=32'hAABBCCDD, period=100, `tx_ready`=1.
  - Expect A5 02 30 11 22 33 44 31 AA BB CC DD 0A.
  - `frame_done` one cycle after 0A.
- **Masked channel:** mask=2'b10 → A5 01 31 AA BB CC DD 0A; channel 0 is absent.
- **Backpressure:** `tx_ready` toggles 1/0 each cycle → identical byte sequence, and `tx_data` is stable during every stall.
- **Overrun:** period=5 with `tx_ready`=0 for 40 cycles.
  - `overrun`=1 and `drop_cnt` equals the number of ticks after the first.
  - `clr_overrun` → both return to 0.
- **Reset mid-frame:** `rst`=0 during DATA → all outputs 0 at the next edge; the first post-reset frame starts with A5.
- **CRC (macro on), basic frame:** the CRC byte equals the CRC-8/0x07 of 02 30 11 22 33 44 31 AA BB CC DD and sits before 0A.
